// File: rtl/matrix_pkg.sv
// matrix_pkg: collector FSM state type and default matrix dimensions shared with the index counter
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} collector_state_t;
  localparam int AROWS_DEF     = 3;
  localparam int ACOLUMNS_DEF  = 3;
  localparam int BCOLUMNS_DEF  = 3;
  localparam int WIDTH_BIT_DEF = 32;
  localparam int ACC_WIDTH_DEF = 32;
endpackage

// File: rtl/matrix_index_tracker.sv
// matrix_index_tracker: k/j/i loop-nest counter for the result collector (k innermost, then j, then i)
// Ports: clk_i/rst_i clock and async active-high reset; clear_i zeroes all counters;
//        advance_k_i steps k (wrapping at ACOLUMNS-1); advance_elem_i steps j then i (wrapping to 0 after
//        the last element); k_o/j_o/i_o current indices; k_last_o, elem_last_o, matrix_last_o bound flags.
module matrix_index_tracker import matrix_pkg::*; #(
  parameter int AROWS     = AROWS_DEF,
  parameter int ACOLUMNS  = ACOLUMNS_DEF,
  parameter int BCOLUMNS  = BCOLUMNS_DEF,
  parameter int WIDTH_BIT = WIDTH_BIT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 advance_k_i,
  input  logic                 advance_elem_i,
  output logic [WIDTH_BIT-1:0] k_o,
  output logic [WIDTH_BIT-1:0] j_o,
  output logic [WIDTH_BIT-1:0] i_o,
  output logic                 k_last_o,
  output logic                 elem_last_o,
  output logic                 matrix_last_o
);
  logic [WIDTH_BIT-1:0] k_q, k_d, j_q, j_d, i_q, i_d;
  assign k_last_o      = k_q == WIDTH_BIT'(ACOLUMNS - 1);
  assign elem_last_o   = j_q == WIDTH_BIT'(BCOLUMNS - 1);
  assign matrix_last_o = elem_last_o && i_q == WIDTH_BIT'(AROWS - 1);
  assign k_o = k_q;
  assign j_o = j_q;
  assign i_o = i_q;
  // Finishing the last element wraps i and j to 0 so the tracker is clean in DONE.
  always_comb begin
    k_d = clear_i ? '0 : advance_k_i ? (k_last_o ? '0 : k_q + WIDTH_BIT'(1)) : k_q;
    j_d = clear_i || (advance_elem_i && elem_last_o) ? '0 : advance_elem_i ? j_q + WIDTH_BIT'(1) : j_q;
    i_d = clear_i || (advance_elem_i && matrix_last_o) ? '0
        : advance_elem_i && elem_last_o ? i_q + WIDTH_BIT'(1) : i_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  end
endmodule

// File: rtl/matrix_result_collector.sv
// matrix_result_collector: sums ACOLUMNS streamed products per C[i][j] and emits each element with its address
// Ports: clock/reset async active-high; start arms one matrix; in_valid/in_ready/in_data product stream;
//        out_valid/out_ready/out_data/out_row/out_col result write port; busy while collecting; done one-cycle pulse.
module matrix_result_collector import matrix_pkg::*; #(
  parameter int AROWS     = AROWS_DEF,
  parameter int ACOLUMNS  = ACOLUMNS_DEF,
  parameter int BCOLUMNS  = BCOLUMNS_DEF,
  parameter int WIDTH_BIT = WIDTH_BIT_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_BIT-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic        [WIDTH_BIT-1:0] out_row,
  output logic        [WIDTH_BIT-1:0] out_col,
  output logic                        busy,
  output logic                        done
);
  collector_state_t state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, data_q, data_d, in_ext, sum;
  logic [WIDTH_BIT-1:0] row_q, row_d, col_q, col_d, k, j, i;
  logic k_last, elem_last, matrix_last, accept, emit;
  if (WIDTH_BIT >= ACC_WIDTH) begin : g_trunc
    assign in_ext = in_data[ACC_WIDTH-1:0];
  end else begin : g_sext
    assign in_ext = {{(ACC_WIDTH-WIDTH_BIT){in_data[WIDTH_BIT-1]}}, in_data};
  end
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == EMIT;
  assign busy      = state_q == ACCUM || state_q == EMIT;
  assign done      = state_q == DONE;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  // The first product of an element restarts the sum, so no explicit clear is needed between elements.
  assign sum = k == '0 ? in_ext : acc_q + in_ext;
  matrix_index_tracker #(
    .AROWS(AROWS), .ACOLUMNS(ACOLUMNS), .BCOLUMNS(BCOLUMNS), .WIDTH_BIT(WIDTH_BIT)
  ) u_idx (
    .clk_i(clock),
    .rst_i(reset),
    .clear_i(state_q == IDLE && start),
    .advance_k_i(accept),
    .advance_elem_i(emit),
    .k_o(k),
    .j_o(j),
    .i_o(i),
    .k_last_o(k_last),
    .elem_last_o(elem_last),
    .matrix_last_o(matrix_last)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (start ? ACCUM : IDLE)
            : state_q == ACCUM ? (accept && k_last ? EMIT : ACCUM)
            : state_q == EMIT  ? (emit ? (matrix_last ? DONE : ACCUM) : EMIT)
            : IDLE;
    acc_d  = accept ? sum : acc_q;
    data_d = accept && k_last ? sum : data_q;
    row_d  = accept && k_last ? i : row_q;
    col_d  = accept && k_last ? j : col_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
endmodule
